tick_timer_scheduler: RTL

Multi-channel countdown scheduler that shares one 1-cycle tick enable, produced by the clock divider, among NUM_CH independent requesters. Each requester arms a timer with a duration in ticks. The block then counts ticks for it with a single shared decrementer, swept round-robin, and returns a one-cycle done pulse on expiry. It sits between the divider and the game/UI FSMs that need second-granularity timeouts.

---
 rtl/tick_timer_scheduler_if.sv | 14 +
 rtl/tick_timer_scheduler.sv | 81 ++++++++
 2 files changed

// File: rtl/tick_timer_scheduler_if.sv
// rtl/tick_timer_scheduler_if.sv - per-channel arm/abort requests and busy/done status
interface tick_timer_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH*CNT_W-1:0] duration;
    logic [NUM_CH-1:0]       cancel;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;

    modport master (output start, output duration, output cancel, input busy, input done);
    modport slave  (input start, input duration, input cancel, output busy, output done);
endinterface

// File: rtl/tick_timer_scheduler.sv
// rtl/tick_timer_scheduler.sv - multi-channel tick countdown with one round-robin decrementer
module tick_timer_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  overrun_clr,
    tick_timer_scheduler_if.slave req,
    output logic                  sweeping,
    output logic                  overrun
);
    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] done_q;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    assign req.busy = busy_q;
    assign req.done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            sweeping <= 1'b0;
            overrun  <= 1'b0;
            busy_q   <= '0;
            done_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            if (state == IDLE) begin
                if (tick) begin
                    state    <= SWEEP;
                    idx      <= '0;
                    sweeping <= 1'b1;
                end
            end else if (idx == IDX_W'(NUM_CH - 1)) begin
                state    <= IDLE;
                sweeping <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end

            // A tick that lands mid-sweep is dropped; only the flag remembers it.
            if (state == SWEEP && tick)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            for (int i = 0; i < NUM_CH; i++) begin
                done_q[i] <= 1'b0;
                if (req.cancel[i]) begin
                    busy_q[i] <= 1'b0;
                    cnt[i]    <= '0;
                end else if (req.start[i]) begin
                    // A start on an armed channel is ignored but still pre-empts its visit.
                    if (!busy_q[i]) begin
                        if (req.duration[i*CNT_W +: CNT_W] != '0) begin
                            cnt[i]    <= req.duration[i*CNT_W +: CNT_W];
                            busy_q[i] <= 1'b1;
                        end else begin
                            done_q[i] <= 1'b1;
                        end
                    end
                end else if (state == SWEEP && idx == IDX_W'(i) && busy_q[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                    if (cnt[i] == CNT_W'(1)) begin
                        busy_q[i] <= 1'b0;
                        done_q[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
